led_shift_sequencer: RTL and testbench

//  Board-level controller that sequences a WIDTH-bit bank of async-reset D flip-flops driving LD1..LDn.

---
 rtl/led_seq_pkg.sv | 22 ++
 rtl/btn_debounce.sv | 60 ++++++
 rtl/led_shift_sequencer.sv | 153 +++++++++++++++
 tb/tb_led_shift_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and parameter helpers for the LED shift sequencer.
package led_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      RUN  = 2'd2
   } state_e;

   // Clock cycles per rotate step.
   function automatic int unsigned calc_step_div(input int unsigned clk_hz,
                                                 input int unsigned step_hz);
      return clk_hz / step_hz;
   endfunction

   // Clock cycles a button level must stay changed before it is accepted.
   function automatic int unsigned calc_db_cnt(input int unsigned clk_hz,
                                               input int unsigned debounce_ms);
      return (clk_hz / 1000) * debounce_ms;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioner: 2-FF synchroniser, debounce counter and
// one-cycle pulse on an accepted rising level.
module btn_debounce
   import led_seq_pkg::*;
#(
   parameter int unsigned DB_CNT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_in,
   output logic level,
   output logic press
);

   localparam int unsigned CW = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;

   logic          sync1_q;
   logic          sync2_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          level_q;
   logic          level_d;
   logic          level_dly_q;
   logic          press_q;

   // Count consecutive cycles of disagreement; any agreement restarts the count.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (sync2_q != level_q) begin
         if (cnt_q == CW'(DB_CNT - 1)) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         cnt_q       <= '0;
         level_q     <= 1'b0;
         level_dly_q <= 1'b0;
         press_q     <= 1'b0;
      end else begin
         sync1_q     <= raw_in;
         sync2_q     <= sync1_q;
         cnt_q       <= cnt_d;
         level_q     <= level_d;
         level_dly_q <= level_q;
         press_q     <= level_q & ~level_dly_q;
      end
   end

   assign level = level_q;
   assign press = press_q;

endmodule

// File: rtl/led_shift_sequencer.sv
// LED bank controller: debounced run/load buttons drive an IDLE/HOLD/RUN
// sequencer that loads, freezes or rotates the LED register at a fixed rate.
module led_shift_sequencer
   import led_seq_pkg::*;
#(
   parameter int unsigned CLK_HZ      = 50_000_000,
   parameter int unsigned STEP_HZ     = 4,
   parameter int unsigned DEBOUNCE_MS = 20,
   parameter int unsigned WIDTH       = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             btn_run,
   input  logic             btn_load,
   input  logic             dir,
   input  logic [WIDTH-1:0] sw,
   output logic [WIDTH-1:0] led,
   output logic             running,
   output logic             step_pulse
);

   localparam int unsigned STEP_DIV = calc_step_div(CLK_HZ, STEP_HZ);
   localparam int unsigned DB_CNT   = calc_db_cnt(CLK_HZ, DEBOUNCE_MS);
   localparam int unsigned PW       = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

   logic             run_press;
   logic             load_press;
   logic             run_level_unused;
   logic             load_level_unused;

   logic             dir_s1_q;
   logic             dir_s2_q;
   logic [WIDTH-1:0] sw_s1_q;
   logic [WIDTH-1:0] sw_s2_q;

   state_e           state_q;
   state_e           state_d;
   logic [WIDTH-1:0] led_q;
   logic [WIDTH-1:0] led_d;
   logic             step_q;
   logic             step_d;
   logic             running_q;
   logic [PW-1:0]    pre_q;
   logic [PW-1:0]    pre_d;
   logic             tick;

   btn_debounce #(
      .DB_CNT (DB_CNT)
   ) u_db_run (
      .clk    (clk),
      .reset  (reset),
      .raw_in (btn_run),
      .level  (run_level_unused),
      .press  (run_press)
   );

   btn_debounce #(
      .DB_CNT (DB_CNT)
   ) u_db_load (
      .clk    (clk),
      .reset  (reset),
      .raw_in (btn_load),
      .level  (load_level_unused),
      .press  (load_press)
   );

   // Switches are level inputs: synchronise only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dir_s1_q <= 1'b0;
         dir_s2_q <= 1'b0;
         sw_s1_q  <= '0;
         sw_s2_q  <= '0;
      end else begin
         dir_s1_q <= dir;
         dir_s2_q <= dir_s1_q;
         sw_s1_q  <= sw;
         sw_s2_q  <= sw_s1_q;
      end
   end

   assign tick = (state_q == RUN) && (pre_q == PW'(STEP_DIV - 1));

   // Next state, LED value and step strobe; load beats run beats tick.
   always_comb begin
      state_d = state_q;
      led_d   = led_q;
      step_d  = 1'b0;
      pre_d   = '0;
      case (state_q)
         IDLE, HOLD: begin
            if (load_press) begin
               led_d   = sw_s2_q;
               state_d = HOLD;
            end else if (run_press) begin
               state_d = RUN;
               if (led_q == '0) begin
                  led_d = WIDTH'(1);
               end
            end
         end
         RUN: begin
            if (load_press) begin
               led_d   = sw_s2_q;
               state_d = HOLD;
            end else if (run_press) begin
               state_d = HOLD;
            end else if (tick) begin
               step_d = 1'b1;
               if (dir_s2_q) begin
                  led_d = {led_q[0], led_q[WIDTH-1:1]};
               end else begin
                  led_d = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Prescaler only advances while staying in RUN; entry starts it at zero.
      if ((state_q == RUN) && (state_d == RUN) && !tick) begin
         pre_d = pre_q + PW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         led_q     <= '0;
         step_q    <= 1'b0;
         running_q <= 1'b0;
         pre_q     <= '0;
      end else begin
         led_q     <= led_d;
         step_q    <= step_d;
         running_q <= (state_d == RUN);
         pre_q     <= pre_d;
      end
   end

   assign led        = led_q;
   assign running    = running_q;
   assign step_pulse = step_q;

endmodule

// File: tb/tb_led_shift_sequencer.sv
// Scoreboard bench for led_shift_sequencer: stimulus queues expected output
// events (cycle, led, running, step_pulse); a negedge monitor pops and compares.
module tb_led_shift_sequencer;

   logic       clk;
   logic       reset;
   logic       btn_run;
   logic       btn_load;
   logic       dir;
   logic [7:0] sw;
   logic [7:0] led;
   logic       running;
   logic       step_pulse;

   typedef struct {
      int         cyc;
      logic [7:0] led;
      logic       running;
      logic       step;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   bit   mon_en = 0;
   logic [7:0] prev_led = 8'h00;
   logic       prev_run = 1'b0;

   led_shift_sequencer #(
      .CLK_HZ      (1000),
      .STEP_HZ     (100),
      .DEBOUNCE_MS (4),
      .WIDTH       (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .btn_run    (btn_run),
      .btn_load   (btn_load),
      .dir        (dir),
      .sw         (sw),
      .led        (led),
      .running    (running),
      .step_pulse (step_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic expect_at(input int c, input logic [7:0] l, input logic r, input logic s);
      exp_t e;
      e.cyc     = c;
      e.led     = l;
      e.running = r;
      e.step    = s;
      sb.push_back(e);
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: an output event is any change of led/running, or a step strobe.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (mon_en) begin
         if (led !== prev_led || running !== prev_run || step_pulse === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event cycle=%0d led=%0h running=%0b step=%0b",
                        cyc, led, running, step_pulse);
            end else begin
               e = sb.pop_front();
               chk("event_cycle", 32'(cyc), 32'(e.cyc));
               chk("event_led", 32'(led), 32'(e.led));
               chk("event_running", 32'(running), 32'(e.running));
               chk("event_step", 32'(step_pulse), 32'(e.step));
            end
         end
         prev_led = led;
         prev_run = running;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int r;
      int p;
      int c;
      reset    = 1'b1;
      btn_run  = 1'b0;
      btn_load = 1'b0;
      dir      = 1'b0;
      sw       = 8'hA5;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_led", 32'(led), 32'h00);
      chk("reset_running", 32'(running), 32'h0);
      chk("reset_step", 32'(step_pulse), 32'h0);
      reset  = 1'b0;
      mon_en = 1'b1;
      @(posedge clk);
      #1;

      // Load A5 from IDLE: pin-to-led latency 8 cycles, lands in HOLD.
      k = cyc;
      expect_at(k + 8, 8'hA5, 1'b0, 1'b0);
      btn_load = 1'b1;
      wait_cyc(k + 10);
      btn_load = 1'b0;
      wait_cyc(k + 20);

      // Load 81, run left: 81 -> 03 -> 06, then run press freezes in HOLD.
      sw = 8'h81;
      k  = cyc;
      expect_at(k + 8, 8'h81, 1'b0, 1'b0);
      btn_load = 1'b1;
      wait_cyc(k + 6);
      btn_load = 1'b0;
      wait_cyc(k + 14);
      r = cyc;
      expect_at(r + 8,  8'h81, 1'b1, 1'b0);
      expect_at(r + 18, 8'h03, 1'b1, 1'b1);
      expect_at(r + 28, 8'h06, 1'b1, 1'b1);
      expect_at(r + 33, 8'h06, 1'b0, 1'b0);
      btn_run = 1'b1;
      wait_cyc(r + 6);
      btn_run = 1'b0;
      wait_cyc(r + 25);
      btn_run = 1'b1;
      wait_cyc(r + 31);
      btn_run = 1'b0;
      wait_cyc(r + 40);

      // Reset to IDLE with led=0, then run right: seeded 01, then 80, 40.
      dir = 1'b1;
      c   = cyc;
      expect_at(c, 8'h00, 1'b0, 1'b0);
      reset = 1'b1;
      #1;
      reset = 1'b0;
      wait_cyc(c + 4);
      r = cyc;
      expect_at(r + 8,  8'h01, 1'b1, 1'b0);
      expect_at(r + 18, 8'h80, 1'b1, 1'b1);
      expect_at(r + 28, 8'h40, 1'b1, 1'b1);
      expect_at(r + 38, 8'h3C, 1'b0, 1'b0);
      btn_run = 1'b1;
      wait_cyc(r + 6);
      btn_run = 1'b0;
      // Short glitches on btn_run must not register as a press.
      wait_cyc(r + 13);
      btn_run = 1'b1;
      wait_cyc(r + 15);
      btn_run = 1'b0;
      wait_cyc(r + 16);
      btn_run = 1'b1;
      wait_cyc(r + 17);
      btn_run = 1'b0;
      wait_cyc(r + 20);
      sw = 8'h3C;
      // Both presses land on the tick edge: load wins, tick dropped.
      wait_cyc(r + 30);
      btn_run  = 1'b1;
      btn_load = 1'b1;
      wait_cyc(r + 36);
      btn_run  = 1'b0;
      btn_load = 1'b0;
      wait_cyc(r + 44);

      // Load 18, run, then async reset mid-RUN before the first tick.
      sw = 8'h18;
      p  = cyc;
      expect_at(p + 8,  8'h18, 1'b0, 1'b0);
      expect_at(p + 22, 8'h18, 1'b1, 1'b0);
      expect_at(p + 25, 8'h00, 1'b0, 1'b0);
      btn_load = 1'b1;
      wait_cyc(p + 6);
      btn_load = 1'b0;
      wait_cyc(p + 14);
      btn_run = 1'b1;
      wait_cyc(p + 20);
      btn_run = 1'b0;
      wait_cyc(p + 25);
      reset = 1'b1;
      #1;
      chk("async_reset_led", 32'(led), 32'h00);
      chk("async_reset_running", 32'(running), 32'h0);
      chk("async_reset_step", 32'(step_pulse), 32'h0);
      reset = 1'b0;
      wait_cyc(p + 45);

      while (sb.size() != 0) begin
         exp_t e;
         e = sb.pop_front();
         checks++;
         errors++;
         $display("FAIL missing_event expected_cycle=%0d led=%0h running=%0b step=%0b",
                  e.cyc, e.led, e.running, e.step);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
